// File: rtl/alu_cmd_sequencer.sv
// Issue stage for an 8-bit combinational ALU: command FIFO, registered ALU drive, result hold.
// Optional ALU_ZERO_FLAG_EN adds a registered res_zero flag captured alongside res_data.
module alu_cmd_sequencer #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DATA_W-1:0]      cmd_a,
    input  logic [DATA_W-1:0]      cmd_b,
    input  logic [SEL_W-1:0]       cmd_sel,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [SEL_W-1:0]       alu_sel,
    input  logic [DATA_W-1:0]      alu_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_W-1:0]      res_data,
    output logic [SEL_W-1:0]       res_sel,
`ifdef ALU_ZERO_FLAG_EN
    output logic                   res_zero,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SEL_W-1:0]  sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t           state;
    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             not_empty;

    assign cmd_ready = (count != CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign push      = cmd_valid && cmd_ready;
    // A pop is only ever an issue event: leaving IDLE, or a result accepted with work queued.
    assign pop       = not_empty && ((state == IDLE) || (state == HOLD && res_ready));
    assign head      = mem[rd_ptr];

    // NOTE: the storage array has no reset; entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
`ifdef ALU_ZERO_FLAG_EN
            res_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a   <= head.a;
                        alu_b   <= head.b;
                        alu_sel <= head.sel;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_data  <= alu_out;
                    res_sel   <= alu_sel;
`ifdef ALU_ZERO_FLAG_EN
                    res_zero  <= (alu_out == '0);
`endif
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            alu_a   <= head.a;
                            alu_b   <= head.b;
                            alu_sel <= head.sel;
                            state   <= ISSUE;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
